// File: rtl/be_pkg.sv
// Shared constants for the data bus responder: default address map,
// timer register offsets and CTRL/STATUS bit positions.
package be_pkg;

    localparam int          RAM_WORDS_DEFAULT = 256;
    localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h1001_0000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    // Byte offsets of the timer registers inside the MMIO block
    localparam logic [3:0] OFF_COUNT  = 4'h0;
    localparam logic [3:0] OFF_CMP    = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    // Bit positions inside CTRL and STATUS
    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_AUTORELOAD_BIT = 1;
    localparam int STATUS_MATCH_BIT    = 0;

    typedef enum logic [1:0] {
        REG_COUNT  = 2'd0,
        REG_CMP    = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } timer_reg_e;

    // Map a block-relative byte offset to a register select; the low two
    // address bits are ignored because only word accesses exist.
    function automatic timer_reg_e reg_from_offset(input logic [3:0] off);
        timer_reg_e sel;
        case ({off[3:2], 2'b00})
            OFF_COUNT:  sel = REG_COUNT;
            OFF_CMP:    sel = REG_CMP;
            OFF_CTRL:   sel = REG_CTRL;
            OFF_STATUS: sel = REG_STATUS;
            default:    sel = REG_COUNT;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Memory-mapped timer: free-running COUNT with compare match, optional
// auto-reload, sticky MATCH flag (write-1-to-clear) and a registered IRQ.
module bus_timer
    import be_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  timer_reg_e  reg_sel,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq_timer
);

    logic [31:0] count_r;
    logic [31:0] cmp_r;
    logic        en_r;
    logic        autoreload_r;
    logic        match_r;
    logic        irq_r;

    logic        hit_s;
    logic        wr_count_s;
    logic        wr_cmp_s;
    logic        wr_ctrl_s;
    logic        w1c_s;

    // Decode register writes and the compare hit for this cycle
    always_comb begin
        hit_s      = en_r && (count_r == cmp_r);
        wr_count_s = wr_en && (reg_sel == REG_COUNT);
        wr_cmp_s   = wr_en && (reg_sel == REG_CMP);
        wr_ctrl_s  = wr_en && (reg_sel == REG_CTRL);
        w1c_s      = wr_en && (reg_sel == REG_STATUS) && wr_data[STATUS_MATCH_BIT];
    end

    // Timer state: software COUNT write beats reload/increment, hardware
    // MATCH set beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r      <= 32'd0;
            cmp_r        <= 32'd0;
            en_r         <= 1'b0;
            autoreload_r <= 1'b0;
            match_r      <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            if (wr_count_s) begin
                count_r <= wr_data;
            end else if (hit_s && autoreload_r) begin
                count_r <= 32'd0;
            end else if (en_r) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end

            if (wr_cmp_s) begin
                cmp_r <= wr_data;
            end

            if (wr_ctrl_s) begin
                en_r         <= wr_data[CTRL_EN_BIT];
                autoreload_r <= wr_data[CTRL_AUTORELOAD_BIT];
            end

            if (hit_s) begin
                match_r <= 1'b1;
            end else if (w1c_s) begin
                match_r <= 1'b0;
            end else begin
                match_r <= match_r;
            end

            irq_r <= match_r;
        end
    end

    // Register read mux; unimplemented CTRL/STATUS bits read as zero
    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            REG_COUNT:  rd_data = count_r;
            REG_CMP:    rd_data = cmp_r;
            REG_CTRL: begin
                rd_data[CTRL_EN_BIT]         = en_r;
                rd_data[CTRL_AUTORELOAD_BIT] = autoreload_r;
            end
            REG_STATUS: rd_data[STATUS_MATCH_BIT] = match_r;
            default:    rd_data = 32'd0;
        endcase
    end

    assign irq_timer = irq_r;

endmodule

// File: rtl/data_bus_responder.sv
// Data-side bus slave for a single-cycle core: word RAM plus the timer
// register block, with zero-latency combinational reads.
module data_bus_responder
    import be_pkg::*;
#(
    parameter int          RAM_WORDS = RAM_WORDS_DEFAULT,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wrdata,
    input  logic        bus_wren,
    input  logic        bus_rden,
    output logic [31:0] bus_rddata,
    output logic        irq_timer
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    logic [31:0]   ram_r [0:RAM_WORDS-1];

    logic [31:0]   ram_off_s;
    logic [AW-1:0] ram_idx_s;
    logic          ram_hit_s;
    logic          mmio_hit_s;
    logic          ram_we_s;
    logic          tmr_we_s;
    timer_reg_e    tmr_sel_s;
    logic [31:0]   tmr_rd_s;

    // Address decode; byte offset within the RAM window gives the word index
    always_comb begin
        ram_off_s  = bus_addr - RAM_BASE;
        ram_hit_s  = (ram_off_s < RAM_BYTES);
        ram_idx_s  = AW'(ram_off_s >> 2);
        mmio_hit_s = (bus_addr[31:4] == MMIO_BASE[31:4]);
        tmr_sel_s  = reg_from_offset(bus_addr[3:0]);
        ram_we_s   = bus_wren && ram_hit_s && !rst;
        tmr_we_s   = bus_wren && mmio_hit_s && !rst;
    end

    // Data RAM: written on the edge, never reset so contents survive rst
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= bus_wrdata;
        end
    end

    bus_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (tmr_we_s),
        .reg_sel   (tmr_sel_s),
        .wr_data   (bus_wrdata),
        .rd_data   (tmr_rd_s),
        .irq_timer (irq_timer)
    );

    // Read data: current (pre-write) contents of the addressed word, else zero
    always_comb begin
        bus_rddata = 32'd0;
        if (rst || !bus_rden) begin
            bus_rddata = 32'd0;
        end else if (ram_hit_s) begin
            bus_rddata = ram_r[ram_idx_s];
        end else if (mmio_hit_s) begin
            bus_rddata = tmr_rd_s;
        end else begin
            bus_rddata = 32'd0;
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM access, address decode,
// timer match/reload/W1C behaviour and asynchronous reset.
module tb_data_bus_responder;

    localparam logic [31:0] RB      = 32'h1001_0000;
    localparam logic [31:0] MB      = 32'hFFFF_0000;
    localparam logic [31:0] COUNT_A = MB + 32'h0;
    localparam logic [31:0] CMP_A   = MB + 32'h4;
    localparam logic [31:0] CTRL_A  = MB + 32'h8;
    localparam logic [31:0] STAT_A  = MB + 32'hC;

    logic        clk;
    logic        rst;
    logic [31:0] bus_addr;
    logic [31:0] bus_wrdata;
    logic        bus_wren;
    logic        bus_rden;
    logic [31:0] bus_rddata;
    logic        irq_timer;

    int n_checks = 0;
    int n_errors = 0;

    data_bus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .bus_addr   (bus_addr),
        .bus_wrdata (bus_wrdata),
        .bus_wren   (bus_wren),
        .bus_rden   (bus_rden),
        .bus_rddata (bus_rddata),
        .irq_timer  (irq_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One write, sampled at the next rising edge; returns 1 unit after it
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_addr   = addr;
        bus_wrdata = data;
        bus_wren   = 1'b1;
        bus_rden   = 1'b0;
        @(posedge clk);
        #1;
        bus_wren = 1'b0;
    endtask

    // Combinational read between edges
    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_addr = addr;
        bus_rden = 1'b1;
        #1;
        chk(tag, bus_rddata, exp);
        bus_rden = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus_addr   = 32'd0;
        bus_wrdata = 32'd0;
        bus_wren   = 1'b0;
        bus_rden   = 1'b0;

        // Reset state
        #12;
        chk("rst_irq", {31'd0, irq_timer}, 32'd0);
        rd("rst_rddata", COUNT_A, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd("rst_count", COUNT_A, 32'd0);
        rd("rst_cmp", CMP_A, 32'd0);
        rd("rst_ctrl", CTRL_A, 32'd0);
        rd("rst_status", STAT_A, 32'd0);

        // RAM write/read, byte offset ignored, boundaries
        wr(RB + 32'h4, 32'hDEAD_BEEF);
        rd("ram_unaligned", RB + 32'h6, 32'hDEAD_BEEF);
        wr(RB, 32'h1234_5678);
        rd("ram_word0", RB + 32'h3, 32'h1234_5678);
        wr(RB + 32'h3FC, 32'hA5A5_5A5A);
        rd("ram_last", RB + 32'h3FC, 32'hA5A5_5A5A);
        rd("ram_past_end", RB + 32'h400, 32'd0);
        rd("below_ram", RB - 32'h4, 32'd0);

        // Same-cycle write and read returns the old word
        @(negedge clk);
        bus_addr   = RB + 32'h4;
        bus_wrdata = 32'h1111_2222;
        bus_wren   = 1'b1;
        bus_rden   = 1'b1;
        #1;
        chk("rw_prewrite", bus_rddata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        bus_wren = 1'b0;
        chk("rw_postwrite", bus_rddata, 32'h1111_2222);
        bus_rden = 1'b0;

        // Unmapped accesses
        rd("unmapped_rd", 32'h2000_0000, 32'd0);
        wr(32'h2000_0000, 32'hFFFF_FFFF);
        wr(MB + 32'h10, 32'hFFFF_FFFF);
        rd("unmapped_ram0", RB, 32'h1234_5678);
        rd("unmapped_ram1", RB + 32'h4, 32'h1111_2222);
        rd("unmapped_cmp", CMP_A, 32'd0);
        rd("unmapped_ctrl", CTRL_A, 32'd0);

        // CTRL upper bits read as zero
        wr(CTRL_A, 32'hFFFF_FFFC);
        rd("ctrl_mask", CTRL_A, 32'd0);

        // Match with auto-reload at COUNT==5
        wr(CMP_A, 32'h5);
        wr(CTRL_A, 32'h3);
        rd("ctrl_rb", CTRL_A, 32'h3);
        rd("ar_count0", COUNT_A, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            rd("ar_count", COUNT_A, 32'(i));
            rd("ar_nomatch", STAT_A, 32'd0);
        end
        @(posedge clk);
        #1;
        rd("ar_match", STAT_A, 32'h1);
        rd("ar_reload", COUNT_A, 32'd0);
        chk("ar_irq_lag", {31'd0, irq_timer}, 32'd0);
        @(posedge clk);
        #1;
        chk("ar_irq", {31'd0, irq_timer}, 32'd1);
        rd("ar_count_after", COUNT_A, 32'h1);

        // W1C racing a match, then a clean W1C
        repeat (4) @(posedge clk);
        #1;
        rd("w1c_pre", COUNT_A, 32'h5);
        wr(STAT_A, 32'h1);
        rd("w1c_race", STAT_A, 32'h1);
        rd("w1c_race_cnt", COUNT_A, 32'd0);
        wr(STAT_A, 32'h1);
        rd("w1c_clear", STAT_A, 32'd0);
        chk("w1c_irq_lag", {31'd0, irq_timer}, 32'd1);
        @(posedge clk);
        #1;
        chk("w1c_irq", {31'd0, irq_timer}, 32'd0);

        // Software COUNT write beats increment; EN=0 freezes COUNT
        wr(COUNT_A, 32'h100);
        rd("sw_count", COUNT_A, 32'h100);
        wr(CTRL_A, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rd("frozen_count", COUNT_A, 32'h101);
        rd("frozen_status", STAT_A, 32'd0);

        // Wrap from all-ones, no auto-reload, match at 0x10
        wr(CMP_A, 32'h10);
        wr(COUNT_A, 32'hFFFF_FFFF);
        wr(CTRL_A, 32'h1);
        rd("wrap_start", COUNT_A, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rd("wrap_zero", COUNT_A, 32'd0);
        repeat (16) @(posedge clk);
        #1;
        rd("wrap_at_cmp", COUNT_A, 32'h10);
        rd("wrap_nomatch", STAT_A, 32'd0);
        @(posedge clk);
        #1;
        rd("wrap_match", STAT_A, 32'h1);
        rd("wrap_noreload", COUNT_A, 32'h11);
        @(posedge clk);
        #1;
        chk("wrap_irq", {31'd0, irq_timer}, 32'd1);

        // Asynchronous reset mid-cycle; RAM preserved, writes suppressed
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_irq", {31'd0, irq_timer}, 32'd0);
        rd("arst_rddata", RB, 32'd0);
        bus_addr   = RB;
        bus_wrdata = 32'h0BAD_0BAD;
        bus_wren   = 1'b1;
        @(posedge clk);
        #1;
        bus_wren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd("arst_count", COUNT_A, 32'd0);
        rd("arst_ctrl", CTRL_A, 32'd0);
        rd("arst_cmp", CMP_A, 32'd0);
        rd("arst_status", STAT_A, 32'd0);
        rd("arst_ram0", RB, 32'h1234_5678);
        rd("arst_ram1", RB + 32'h4, 32'h1111_2222);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
